// File: rtl/dr_alm_pipe.sv
// Pipelined dynamic-range approximate log multiplier. DR_ALM_PIPE_STATS_EN adds delivery counters.
// Latency 3 cycles (S1 normalise, S2 add, S3 shift/sign), one result per cycle.
// Backpressure: each stage holds when full and blocked; in_ready follows out_ready combinationally.
module dr_alm_pipe #(
  parameter int WIDTH      = 16,
  parameter int KEEP_WIDTH = 5,
  parameter int SIGNED     = 1,
  parameter int TAG_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_rnd,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_z,
  output logic [TAG_W-1:0]     out_tag
`ifdef DR_ALM_PIPE_STATS_EN
  ,
  output logic [31:0]          stat_count,
  output logic [31:0]          stat_zero
`endif
);

  localparam int W  = WIDTH;
  localparam int T  = KEEP_WIDTH;
  localparam int LW = $clog2(W);
  localparam int KW = $clog2(2 * W);
  localparam int ZW = 2 * W;

  typedef struct packed {
    logic             s;
    logic [LW-1:0]    ka;
    logic [LW-1:0]    kb;
    logic [T-1:0]     xa;
    logic [T-1:0]     xb;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             s;
    logic [KW-1:0]    k;
    logic [T:0]       m;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } s2_t;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    if ((SIGNED != 0) && v[W-1]) return ~v + W'(1);
    return v;
  endfunction

  function automatic logic [LW-1:0] lead_one(input logic [W-1:0] v);
    logic [LW-1:0] k;
    k = '0;
    for (int i = 0; i < W; i++) if (v[i]) k = LW'(i);
    return k;
  endfunction

  logic v1_q, v2_q, v3_q;
  logic s1_adv, s2_adv, s3_adv;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [ZW-1:0]    z_d, z_q;
  logic [TAG_W-1:0] tag3_q;

  assign s3_adv   = !v3_q || out_ready;
  assign s2_adv   = !v2_q || s3_adv;
  assign s1_adv   = !v1_q || s2_adv;
  assign in_ready = s1_adv;

  logic [W-1:0]  mag_a, mag_b, norm_a, norm_b;
  logic [LW-1:0] k_a, k_b;
  logic          unused_norm;

  // Only the bits just below the leading one survive into the T-bit significand.
  always_comb begin
    mag_a       = mag(in_a);
    mag_b       = mag(in_b);
    k_a         = lead_one(mag_a);
    k_b         = lead_one(mag_b);
    norm_a      = mag_a << (LW'(W - 1) - k_a);
    norm_b      = mag_b << (LW'(W - 1) - k_b);
    s1_d        = '0;
    s1_d.s      = (SIGNED != 0) ? (in_a[W-1] ^ in_b[W-1]) : 1'b0;
    s1_d.ka     = k_a;
    s1_d.kb     = k_b;
    s1_d.xa     = {norm_a[W-2 -: T-1], in_rnd ? norm_a[W-1-T] : 1'b1};
    s1_d.xb     = {norm_b[W-2 -: T-1], in_rnd ? norm_b[W-1-T] : 1'b1};
    s1_d.zero   = (in_a == '0) || (in_b == '0);
    s1_d.tag    = in_tag;
  end

  assign unused_norm = ^{norm_a, norm_b};

  logic [T:0] sum_x;

  always_comb begin
    sum_x     = {1'b0, s1_q.xa} + {1'b0, s1_q.xb} + (T+1)'(1);
    s2_d      = '0;
    s2_d.s    = s1_q.s;
    s2_d.k    = KW'(s1_q.ka) + KW'(s1_q.kb) + KW'(sum_x[T]);
    s2_d.m    = {1'b1, sum_x[T-1:0]};
    s2_d.zero = s1_q.zero;
    s2_d.tag  = s1_q.tag;
  end

  logic [ZW-1:0] m_w, z_mag;

  always_comb begin
    m_w = ZW'(s2_q.m);
    if (s2_q.k >= KW'(T)) z_mag = m_w << (s2_q.k - KW'(T));
    else                  z_mag = m_w >> (KW'(T) - s2_q.k);
    if (s2_q.zero)        z_d = '0;
    else if (s2_q.s)      z_d = ~z_mag + ZW'(1);
    else                  z_d = z_mag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      z_q    <= '0;
      tag3_q <= '0;
    end else begin
      if (s1_adv) begin
        v1_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        v2_q <= v1_q;
        if (v1_q) s2_q <= s2_d;
      end
      if (s3_adv) begin
        v3_q <= v2_q;
        if (v2_q) begin
          z_q    <= z_d;
          tag3_q <= s2_q.tag;
        end
      end
    end
  end

  assign out_valid = v3_q;
  assign out_z     = z_q;
  assign out_tag   = tag3_q;

`ifdef DR_ALM_PIPE_STATS_EN
  logic        zero3_q;
  logic [31:0] cnt_q, cnt_zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero3_q    <= 1'b0;
      cnt_q      <= '0;
      cnt_zero_q <= '0;
    end else begin
      if (s3_adv && v2_q) zero3_q <= s2_q.zero;
      if (v3_q && out_ready) begin
        cnt_q <= cnt_q + 32'd1;
        if (zero3_q) cnt_zero_q <= cnt_zero_q + 32'd1;
      end
    end
  end

  assign stat_count = cnt_q;
  assign stat_zero  = cnt_zero_q;
`endif

endmodule

// File: tb/tb_dr_alm_pipe.sv
// Directed bench for dr_alm_pipe at WIDTH=8, KEEP_WIDTH=4, SIGNED=1.
module tb_dr_alm_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_rnd;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic [3:0]  out_tag;
`ifdef DR_ALM_PIPE_STATS_EN
  logic [31:0] stat_count;
  logic [31:0] stat_zero;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dr_alm_pipe #(.WIDTH(8), .KEEP_WIDTH(4), .SIGNED(1), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rnd    (in_rnd),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_tag   (out_tag)
`ifdef DR_ALM_PIPE_STATS_EN
    ,
    .stat_count(stat_count),
    .stat_zero (stat_zero)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One isolated transaction, out_ready held high, exact 3-cycle latency.
  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic rnd,
                         input logic [3:0] tg, input logic [15:0] exp_z);
    @(negedge clk);
    in_a = a; in_b = b; in_rnd = rnd; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    chk("dir_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk("dir_lat1", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("dir_lat2", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("dir_valid", 64'(out_valid), 64'(1));
    chk("dir_z", 64'(out_z), 64'(exp_z));
    chk("dir_tag", 64'(out_tag), 64'(tg));
  endtask

  logic [7:0]  sa [10] = '{8'd3, 8'd3, 8'hFB, 8'hFB, 8'd0, 8'h80, 8'd1, 8'd2, 8'hFF, 8'd127};
  logic [7:0]  sb [10] = '{8'd3, 8'd3, 8'd7, 8'd7, 8'h9C, 8'h80, 8'd1, 8'd5, 8'd1, 8'd127};
  logic        sr [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] sz [10] = '{16'd9, 16'd8, 16'hFFDA, 16'hFFDE, 16'd0, 16'h4C00,
                           16'd1, 16'd10, 16'hFFFF, 16'h3E00};
  logic [3:0]  st [10] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
  logic [39:0] pat = 40'hFF_F5_6D_35_C0;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int pushed, popped, full_seen;
    logic stalled, ghost;
    logic [15:0] hz;
    logic [3:0] ht;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_rnd = 1'b0; in_tag = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_z", 64'(out_z), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    run_one(8'd3,  8'd3,  1'b0, 4'd5, 16'd9);
    run_one(8'd3,  8'd3,  1'b1, 4'd6, 16'd8);
    run_one(8'hFB, 8'd7,  1'b0, 4'd1, 16'hFFDA);
    run_one(8'hFB, 8'd7,  1'b1, 4'd2, 16'hFFDE);
    run_one(8'd0,  8'h9C, 1'b0, 4'd7, 16'd0);
    run_one(8'h80, 8'h80, 1'b0, 4'd15, 16'h4C00);

    // Streaming with a fixed out_ready pattern; in_ready must close only when 3 are held.
    pushed = 0; popped = 0; full_seen = 0; stalled = 1'b0; hz = '0; ht = '0;
    for (int cyc = 0; cyc < 200 && popped < 10; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_z", 64'(out_z), 64'(hz));
        chk("hold_tag", 64'(out_tag), 64'(ht));
      end
      out_ready = (cyc < 40) ? pat[cyc[5:0]] : 1'b1;
      if (pushed < 10) begin
        in_valid = 1'b1; in_a = sa[pushed]; in_b = sb[pushed];
        in_rnd = sr[pushed]; in_tag = st[pushed];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready && (pushed - popped) == 3) begin
        full_seen++;
        chk("str_full_block", 64'(in_ready), 64'(0));
      end else begin
        chk("str_in_ready", 64'(in_ready), 64'(1));
      end
      if (out_valid && out_ready) begin
        chk("str_z", 64'(out_z), 64'(sz[popped]));
        chk("str_tag", 64'(out_tag), 64'(st[popped]));
        popped++;
      end
      stalled = out_valid && !out_ready;
      hz = out_z; ht = out_tag;
      if (in_valid && in_ready) pushed++;
    end
    chk("str_delivered", 64'(popped), 64'(10));
    chk("str_full_seen", 64'(full_seen != 0), 64'(1));

    // Fill the pipe, then pulse reset for one cycle.
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3; in_rnd = 1'b0; in_tag = 4'(9 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_z", 64'(out_z), 64'(0));
    chk("mid_rst_tag", 64'(out_tag), 64'(0));
    rst_n = 1'b1; out_ready = 1'b1;
    ghost = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) ghost = 1'b1;
    end
    chk("flushed_never_out", 64'(ghost), 64'(0));

`ifdef DR_ALM_PIPE_STATS_EN
    begin
      logic [7:0] ka [6] = '{8'd3, 8'd0, 8'hFB, 8'd7, 8'd1, 8'd2};
      logic [7:0] kb [6] = '{8'd3, 8'd5, 8'd7, 8'd0, 8'd1, 8'd5};
      logic       kst[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int w;
      chk("stat_count_rst", 64'(stat_count), 64'(0));
      chk("stat_zero_rst", 64'(stat_zero), 64'(0));
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        out_ready = !kst[i];
        in_valid = 1'b1; in_a = ka[i]; in_b = kb[i]; in_rnd = 1'b0; in_tag = 4'(i);
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin
          @(negedge clk);
          w++;
        end
        chk("stat_arrive", 64'(out_valid), 64'(1));
        if (kst[i]) begin
          repeat (3) @(negedge clk);
          chk("stat_no_double", 64'(stat_count), 64'(i));
          out_ready = 1'b1;
        end
      end
      @(negedge clk);
      @(negedge clk);
      chk("stat_count", 64'(stat_count), 64'(6));
      chk("stat_zero", 64'(stat_zero), 64'(2));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dr_alm_pipe.md
Name: dr_alm_pipe

Overview:
- Pipelined, parametrised dynamic-range approximate logarithmic multiplier (DR-ALM) with a valid/ready stream interface.
- The rounding mode is selected per transaction, and an opaque tag travels alongside each operand pair.
- It replaces the combinational DR-ALM in datapaths that need timing closure at larger WIDTH, and it sits between operand FIFOs and the accumulator stage.

Parameters:
- WIDTH, 16, operand width in bits; legal range 4..32.
- KEEP_WIDTH, 5, truncated significand width T; legal range 2..WIDTH-1.
- SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned.
- TAG_W, 4, sideband tag width; minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  pipeline accepts the pair this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_rnd  in  1  LSB mode: 0 = forced '1', 1 = first discarded bit.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_z  out  2*WIDTH  approximate product.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: all stage valid bits are cleared and in-flight data is dropped; this also applies to a reset asserted mid-operation. out_valid=0, out_z=0, out_tag=0. in_ready goes high in the first cycle after reset deasserts.
- Handshake:
  - A transfer occurs on valid&&ready at both ports.
  - Stage n advances when it is empty or stage n+1 advances; S3 advances when out_ready=1 or S3 is empty.
  - in_ready = S1 empty or S1 advances. This path is combinational from out_ready.
  - Bubbles collapse.
  - While out_valid=1 && out_ready=0, out_z and out_tag hold stable.
- Latency: 3 cycles from input handshake to out_valid with out_ready held high. Throughput is 1 result per cycle.
- Stage S1:
  - Sign s = SIGNED ? a[W-1]^b[W-1] : 0.
  - |a|,|b| are taken as W-bit unsigned; the most negative value maps to 2^(W-1).
  - k = index of the leading one.
  - norm = |x| << (W-1-k).
  - f = norm[W-2 -: T-1].
  - lsb = rnd ? norm[W-1-T] : 1.
  - x = {f, lsb}, T bits.
  - zero flag = (a==0) || (b==0).
- Stage S2:
  - sum_x = xa + xb + 1, T+1 bits.
  - carry = sum_x[T].
  - K = ka + kb + carry.
  - m = {1, sum_x[T-1:0]}.
- Stage S3:
  - If K >= T, z = m << (K-T); otherwise z = m >> (T-K).
  - Result is negated if s; z = 0 when the zero flag is set.
  - All arithmetic is in 2*WIDTH bits; no saturation is applied (the range fits by construction).
- Tag and rnd are captured with their operands and never mix between transactions.
- Simultaneous input accept and output drain in the same cycle is legal when full. No stall occurs while out_ready=1.

Optional Feature:
- Macro DR_ALM_PIPE_STATS_EN.
- When defined:
  - Adds outputs stat_count (32-bit, results delivered, i.e. out handshakes) and stat_zero (32-bit, delivered results whose zero flag was set).
  - Both counters wrap at 2^32 and are cleared by rst_n.
  - Counters increment only on an out handshake; a stalled result is not double-counted.
- When undefined: neither port nor counter logic exists; behaviour is otherwise identical.

Test Plan:
- W=8, T=4, SIGNED=1, rnd=0, a=3, b=3, tag=5, out_ready=1 -> out_z=9 with tag 5 exactly 3 cycles after accept; rnd=1 gives 8.
- W=8, T=4, a=-5, b=7: rnd=0 -> out_z=-38; rnd=1 -> out_z=-34. a=0, b=-100 -> out_z=0.
- W=8, T=4, a=-128, b=-128, rnd=0 -> out_z=19456 (sign positive, no overflow).
- Stream of 10 tagged pairs with out_ready toggling on a random pattern:
  - results arrive in order with matching tags;
  - out_z and out_tag hold while stalled;
  - in_ready=0 when 3 results are held and out_ready=0.
- rst_n pulled low for 1 cycle with 3 transactions in flight -> out_valid=0 and out_z=0 next cycle; the flushed transactions never appear.
- With DR_ALM_PIPE_STATS_EN: 6 results including 2 zero-operand pairs, 2 of them stalled for 3 cycles -> stat_count=6, stat_zero=2.
